tipi_rpi_serial_ctrl: RTL and testbench
=======================================

// Module: tipi_rpi_serial_ctrl
// PURPOSE
//  Serial register-exchange controller between the TI-side TIPI latches and the Raspberry Pi.
//  - Holds the TI->RPi registers TD/TC and the RPi->TI registers RD/RC.
//  - The RPi moves any register in an 8-bit frame over 4 GPIO lines (sclk, le, regsel, sdata).
//  - All RPi inputs are synchronised into the 50 MHz clk domain.
//  - The TI bus decoder supplies single-cycle write pulses and reads rd_q/rc_q through its output mux.
// PARAMETERS
//  SYNC_STAGES  2  flops per RPi input synchroniser (legal values 2..3)
//  DATA_W       8  register and frame width
// PORTS
//  clk            in   1       50 MHz system clock; the block's only clock
//  rst_n          in   1       asynchronous, active-low reset
//  ti_td_wr       in   1       1-clk pulse: TI wrote 0x5fff; load ti_wdata into TD
//  ti_tc_wr       in   1       1-clk pulse: TI wrote 0x5ffd; load ti_wdata into TC
//  ti_wdata       in   DATA_W  TI write data, MSB = bit 7
//  td_q           out  DATA_W  TD register
//  tc_q           out  DATA_W  TC register, also drives the LEDs
//  rd_q           out  DATA_W  RD register; TI reads it at 0x5ffb
//  rc_q           out  DATA_W  RC register; TI reads it at 0x5ff9
//  rpi_sclk       in   1       async shift clock; the block acts on its rising edge
//  rpi_le         in   1       async frame enable, active low; idles high
//  rpi_regsel     in   2       async register select: 00 TD, 01 TC, 10 RD, 11 RC
//  rpi_sdata_in   in   1       async serial data from the RPi, MSB first
//  rpi_sdata_out  out  1       serial data to the RPi; equals shift_q[DATA_W-1]
//  rd_wr_stb      out  1       1-clk pulse when RD is committed
//  rc_wr_stb      out  1       1-clk pulse when RC is committed
//  frame_err      out  1       1-clk pulse when a frame is aborted
//  busy           out  1       high while the FSM is not in IDLE
// BEHAVIOUR
//  - Reset values:
//    - td/tc/rd/rc, shift_q, bit_cnt, all strobes and busy reset to 0; FSM resets to IDLE.
//    - le synchroniser flops reset to 1 and sclk synchroniser flops reset to 0, so reset release makes no false edge.
//  - Edges: le_fall, le_rise and sclk_rise are detected on the last synchroniser stage.
//    - Latency from a pin edge to its internal event is SYNC_STAGES+1 clks.
//    - RPi timing rule: sclk high and low phases, and le setup/hold around sclk, are each >= SYNC_STAGES+2 clks.
//  - TI writes: ti_td_wr loads TD and ti_tc_wr loads TC on the next clk edge, in any FSM state.
//    - The TI side never writes RD or RC.
//  - FSM states IDLE, SHIFT, COMMIT:
//    - IDLE -> SHIFT on le_fall.
//      - Capture synced regsel into sel_q and clear bit_cnt.
//      - For sel TD/TC, load shift_q from the register. If a TI write to the same register occurs in that cycle, load ti_wdata instead (bypass).
//      - For sel RD/RC, load shift_q with 0.
//    - SHIFT on sclk_rise: shift_q <= {shift_q[DATA_W-2:0], sdata_in_sync}; bit_cnt++.
//    - SHIFT on le_rise with bit_cnt == DATA_W: go to COMMIT.
//    - SHIFT on le_rise with bit_cnt != DATA_W: abort. Pulse frame_err and return to IDLE with no commit.
//    - SHIFT: a ninth sclk_rise (bit_cnt already at DATA_W) sets an overrun flag; the following le_rise aborts the frame.
//    - COMMIT (1 clk):
//      - sel RD: rd_q <= shift_q and pulse rd_wr_stb. sel RC: rc_q <= shift_q and pulse rc_wr_stb.
//      - sel TD/TC: no register change.
//      - Then go to IDLE.
//  - A read frame of TD/TC is non-destructive.
//  - A TI write during a read frame updates td_q/tc_q, but the frame keeps shifting its original snapshot.
//  - Simultaneous sclk_rise with le_fall or le_rise: the le event wins and that sclk edge is dropped.
//  - A change on regsel mid-frame is ignored; only sel_q is used.
//  - le_rise in IDLE is ignored. le_fall in COMMIT is ignored; the RPi must respect the timing rule.
//  - Asserting rst_n low mid-frame returns the FSM to IDLE immediately, clears all state and commits nothing.
//  - bit_cnt is $clog2(DATA_W)+1 bits wide and saturates at DATA_W; it never wraps.
// STRUCTURE
//  - Shared include tipi_defs.vh holds:
//    - REGSEL_TD=2'b00, REGSEL_TC=2'b01, REGSEL_RD=2'b10, REGSEL_RC=2'b11
//    - FSM state encodings ST_IDLE, ST_SHIFT, ST_COMMIT
//    - TIPI_DATA_W=8
//  - Sub-module tipi_sync_edge: parameterised SYNC_STAGES synchroniser with selectable reset value, providing sync, rise and fall outputs.
//    - Instantiated for sclk and le.
//    - sdata_in and regsel[1:0] use the same synchroniser with the edge outputs unused.
//  - Top level contains the FSM, shift register, bit counter and the four holding registers.
// TESTING
//  1. Reset release with le=1, sclk=0 -> busy=0, all registers 0x00, no strobes for 20 clks.
//  2. TI pulses ti_td_wr with 0xA5, then the RPi runs a TD frame of 8 sclks -> rpi_sdata_out sequence is 1,0,1,0,0,1,0,1; td_q stays 0xA5.
//  3. RPi RC frame shifting in 0x3C -> rc_q=0x3C and rc_wr_stb pulses exactly once, SYNC_STAGES+2 clks after le rises; rd_q unchanged.
//  4. RD frame with only 7 sclks, then le high -> frame_err pulses once and rd_q keeps its old value. A 9-sclk frame gives the same result.
//  5. ti_tc_wr with 0x81 in the same clk as the internal le_fall with regsel=TC -> shifted-out byte is 0x81.
//     A further TI write of 0x00 mid-frame -> tc_q=0x00 and the frame still shifts 0x81.
//  6. rst_n asserted after 4 sclks of an RD frame -> busy=0 at once, rd_q=0x00, no rd_wr_stb; a following full frame with 0xFF commits 0xFF.

Source files
------------

// File: rtl/tipi_rpi_serial_ctrl_pkg.sv
// Shared definitions for the TIPI <-> Raspberry Pi serial register exchange.
// Covers the register-select codes, the FSM state encodings and the default data width.
package tipi_rpi_serial_ctrl_pkg;

    localparam int TIPI_DATA_W = 8;

    // Register addressed by a serial frame.
    typedef enum logic [1:0] {
        REGSEL_TD = 2'b00,
        REGSEL_TC = 2'b01,
        REGSEL_RD = 2'b10,
        REGSEL_RC = 2'b11
    } regsel_e;

    // Frame controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_COMMIT = 2'b10
    } state_e;

endpackage

// File: rtl/tipi_sync_edge.sv
// Multi-flop synchroniser for asynchronous RPi GPIO inputs.
// Produces the synchronised level plus rise/fall strobes.
// The strobes are taken from the last stage against its delayed copy.
// The reset value is chosen per bit, so that releasing reset never fakes an edge.
module tipi_sync_edge #(
    parameter int               SYNC_STAGES = 2,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= RST_VAL;
            end
            prev_r <= RST_VAL;
        end else begin
            stage_r[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            prev_r <= stage_r[SYNC_STAGES-1];
        end
    end

    assign sync = stage_r[SYNC_STAGES-1];
    assign rise = stage_r[SYNC_STAGES-1] & ~prev_r;
    assign fall = ~stage_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/tipi_rpi_serial_ctrl.sv
// TIPI serial register-exchange controller.
// Holds TD/TC (TI -> RPi) and RD/RC (RPi -> TI).
// The RPi moves any of these registers in an 8-bit, MSB-first frame: le low, 8 sclk rises, le high.
// Writes to RD/RC are committed only when the frame is well-formed.
module tipi_rpi_serial_ctrl
    import tipi_rpi_serial_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = TIPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ti_td_wr,
    input  logic              ti_tc_wr,
    input  logic [DATA_W-1:0] ti_wdata,
    output logic [DATA_W-1:0] td_q,
    output logic [DATA_W-1:0] tc_q,
    output logic [DATA_W-1:0] rd_q,
    output logic [DATA_W-1:0] rc_q,
    input  logic              rpi_sclk,
    input  logic              rpi_le,
    input  logic [1:0]        rpi_regsel,
    input  logic              rpi_sdata_in,
    output logic              rpi_sdata_out,
    output logic              rd_wr_stb,
    output logic              rc_wr_stb,
    output logic              frame_err,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronised RPi inputs
    logic       sclk_rise_s;
    logic       le_rise_s;
    logic       le_fall_s;
    logic [2:0] data_sync_s;
    logic       sclk_sync_unused_s;
    logic       sclk_fall_unused_s;
    logic       le_sync_unused_s;
    logic [2:0] data_rise_unused_s;
    logic [2:0] data_fall_unused_s;

    // Frame state
    state_e            state_r;
    state_e            state_nxt_s;
    regsel_e           sel_r;
    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              overrun_r;
    logic              busy_r;

    // FSM decisions for the current cycle
    logic              frame_start_s;
    logic              shift_en_s;
    logic              overrun_set_s;
    logic              commit_s;
    logic              abort_s;
    logic [DATA_W-1:0] frame_load_s;

    tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rpi_sclk),
        .sync     (sclk_sync_unused_s),
        .rise     (sclk_rise_s),
        .fall     (sclk_fall_unused_s)
    );

    tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_le (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rpi_le),
        .sync     (le_sync_unused_s),
        .rise     (le_rise_s),
        .fall     (le_fall_s)
    );

    tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(3), .RST_VAL(3'b000)) u_sync_data (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in ({rpi_regsel, rpi_sdata_in}),
        .sync     (data_sync_s),
        .rise     (data_rise_unused_s),
        .fall     (data_fall_unused_s)
    );

    // Next-state logic; le events take priority over a coincident sclk edge
    always_comb begin
        state_nxt_s   = state_r;
        frame_start_s = 1'b0;
        shift_en_s    = 1'b0;
        overrun_set_s = 1'b0;
        commit_s      = 1'b0;
        abort_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (le_fall_s) begin
                    state_nxt_s   = ST_SHIFT;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (le_rise_s) begin
                    if ((bit_cnt_r == CNT_FULL) && !overrun_r) begin
                        state_nxt_s = ST_COMMIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        abort_s     = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    if (bit_cnt_r == CNT_FULL) begin
                        overrun_set_s = 1'b1;
                    end else begin
                        shift_en_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
                commit_s    = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Snapshot loaded at frame start; a same-cycle TI write is bypassed in
    always_comb begin
        frame_load_s = {DATA_W{1'b0}};
        case (data_sync_s[2:1])
            REGSEL_TD: begin
                if (ti_td_wr) begin
                    frame_load_s = ti_wdata;
                end else begin
                    frame_load_s = td_q;
                end
            end
            REGSEL_TC: begin
                if (ti_tc_wr) begin
                    frame_load_s = ti_wdata;
                end else begin
                    frame_load_s = tc_q;
                end
            end
            default: begin
                frame_load_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // FSM state register and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Frame datapath: select capture, shift register, saturating bit counter, overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= REGSEL_TD;
            shift_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            overrun_r <= 1'b0;
        end else if (frame_start_s) begin
            sel_r     <= regsel_e'(data_sync_s[2:1]);
            shift_r   <= frame_load_s;
            bit_cnt_r <= {CNT_W{1'b0}};
            overrun_r <= 1'b0;
        end else if (shift_en_s) begin
            shift_r   <= {shift_r[DATA_W-2:0], data_sync_s[0]};
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end else if (overrun_set_s) begin
            overrun_r <= 1'b1;
        end
    end

    // TI-written holding registers; writable in any FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            td_q <= {DATA_W{1'b0}};
            tc_q <= {DATA_W{1'b0}};
        end else begin
            if (ti_td_wr) begin
                td_q <= ti_wdata;
            end
            if (ti_tc_wr) begin
                tc_q <= ti_wdata;
            end
        end
    end

    // RPi-written holding registers and the commit/abort strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= {DATA_W{1'b0}};
            rc_q      <= {DATA_W{1'b0}};
            rd_wr_stb <= 1'b0;
            rc_wr_stb <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rd_wr_stb <= commit_s && (sel_r == REGSEL_RD);
            rc_wr_stb <= commit_s && (sel_r == REGSEL_RC);
            frame_err <= abort_s;
            if (commit_s && (sel_r == REGSEL_RD)) begin
                rd_q <= shift_r;
            end
            if (commit_s && (sel_r == REGSEL_RC)) begin
                rc_q <= shift_r;
            end
        end
    end

    assign rpi_sdata_out = shift_r[DATA_W-1];
    assign busy          = busy_r;

endmodule

// File: tb/tb_tipi_rpi_serial_ctrl.sv
// Directed bench for tipi_rpi_serial_ctrl.
// Drives TI write pulses and bit-banged RPi frames on the negative clock edge.
// Checks outputs against hand-computed values on the same edge.
module tb_tipi_rpi_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ti_td_wr;
    logic       ti_tc_wr;
    logic [7:0] ti_wdata;
    logic [7:0] td_q;
    logic [7:0] tc_q;
    logic [7:0] rd_q;
    logic [7:0] rc_q;
    logic       rpi_sclk;
    logic       rpi_le;
    logic [1:0] rpi_regsel;
    logic       rpi_sdata_in;
    logic       rpi_sdata_out;
    logic       rd_wr_stb;
    logic       rc_wr_stb;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_stb_cnt = 0;
    int rc_stb_cnt = 0;
    int err_cnt = 0;
    int rc_stb_cyc = 0;
    int le_rise_cyc = 0;

    tipi_rpi_serial_ctrl #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ti_td_wr      (ti_td_wr),
        .ti_tc_wr      (ti_tc_wr),
        .ti_wdata      (ti_wdata),
        .td_q          (td_q),
        .tc_q          (tc_q),
        .rd_q          (rd_q),
        .rc_q          (rc_q),
        .rpi_sclk      (rpi_sclk),
        .rpi_le        (rpi_le),
        .rpi_regsel    (rpi_regsel),
        .rpi_sdata_in  (rpi_sdata_in),
        .rpi_sdata_out (rpi_sdata_out),
        .rd_wr_stb     (rd_wr_stb),
        .rc_wr_stb     (rc_wr_stb),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Count of rising clock edges
    always @(posedge clk) cyc <= cyc + 1;

    // Count the strobe pulses seen on the falling clock edge
    always @(negedge clk) begin
        if (rd_wr_stb) rd_stb_cnt <= rd_stb_cnt + 1;
        if (rc_wr_stb) begin
            rc_stb_cnt <= rc_stb_cnt + 1;
            rc_stb_cyc <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ti_write(input logic tc, input logic [7:0] d);
        ti_wdata = d;
        if (tc) ti_tc_wr = 1'b1; else ti_td_wr = 1'b1;
        wait_clks(1);
        ti_td_wr = 1'b0;
        ti_tc_wr = 1'b0;
    endtask

    task automatic frame_open(input logic [1:0] sel);
        rpi_regsel = sel;
        rpi_le     = 1'b0;
        wait_clks(6);
        check("busy_in_frame", busy, 1);
    endtask

    // One bit: present data, note the bit the DUT is driving, then a full sclk pulse
    task automatic send_bit(input logic b, output logic o);
        rpi_sdata_in = b;
        wait_clks(2);
        o = rpi_sdata_out;
        rpi_sclk = 1'b1;
        wait_clks(6);
        rpi_sclk = 1'b0;
        wait_clks(4);
    endtask

    task automatic frame_close();
        wait_clks(2);
        rpi_le      = 1'b1;
        le_rise_cyc = cyc;
        wait_clks(8);
    endtask

    task automatic run_frame(input logic [1:0] sel, input logic [7:0] din, input int nbits,
                             output logic [7:0] dout);
        logic o;
        dout = 8'h00;
        frame_open(sel);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 8) ? din[7-i] : 1'b0, o);
            if (i < 8) dout[7-i] = o;
        end
        frame_close();
    endtask

    initial begin
        logic [7:0] got;
        logic       o;
        int         rd_before;
        int         err_before;

        rst_n        = 1'b0;
        ti_td_wr     = 1'b0;
        ti_tc_wr     = 1'b0;
        ti_wdata     = 8'h00;
        rpi_sclk     = 1'b0;
        rpi_le       = 1'b1;
        rpi_regsel   = 2'b00;
        rpi_sdata_in = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;

        // 1: quiet after reset release
        wait_clks(20);
        check("rst_busy", busy, 0);
        check("rst_regs", {td_q, tc_q, rd_q, rc_q}, 32'h0);
        check("rst_strobes", rd_stb_cnt + rc_stb_cnt + err_cnt, 0);
        check("rst_sdata_out", rpi_sdata_out, 0);

        // 2: TD read frame returns TI-written byte, non-destructively
        ti_write(1'b0, 8'hA5);
        check("td_written", td_q, 8'hA5);
        run_frame(2'b00, 8'h00, 8, got);
        check("td_shift_out", got, 8'hA5);
        check("td_kept", td_q, 8'hA5);
        check("busy_after_frame", busy, 0);

        // 3: RC write frame commits with one strobe at le_rise + 4 clks
        run_frame(2'b11, 8'h3C, 8, got);
        check("rc_value", rc_q, 8'h3C);
        check("rc_stb_count", rc_stb_cnt, 1);
        check("rc_stb_latency", rc_stb_cyc - le_rise_cyc, 4);
        check("rc_rd_untouched", rd_q, 8'h00);
        check("rc_no_err", err_cnt, 0);

        // 4: good RD frame, then short and overlong frames abort
        run_frame(2'b10, 8'h5A, 8, got);
        check("rd_value", rd_q, 8'h5A);
        check("rd_stb_count", rd_stb_cnt, 1);
        run_frame(2'b10, 8'hFF, 7, got);
        check("short_err", err_cnt, 1);
        check("short_rd_kept", rd_q, 8'h5A);
        run_frame(2'b10, 8'hFF, 9, got);
        check("long_err", err_cnt, 2);
        check("long_rd_kept", rd_q, 8'h5A);
        check("abort_no_rd_stb", rd_stb_cnt, 1);

        // 5: TC write coincident with internal le_fall is bypassed into the frame
        rpi_regsel = 2'b01;
        rpi_le     = 1'b0;
        wait_clks(2);
        ti_tc_wr = 1'b1;
        ti_wdata = 8'h81;
        wait_clks(1);
        ti_tc_wr = 1'b0;
        wait_clks(3);
        check("tc_bypass_written", tc_q, 8'h81);
        got = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0, o);
            got[7-i] = o;
        end
        ti_write(1'b1, 8'h00);
        rpi_regsel = 2'b10;
        check("tc_mid_write", tc_q, 8'h00);
        for (int i = 4; i < 8; i++) begin
            send_bit(1'b0, o);
            got[7-i] = o;
        end
        frame_close();
        check("tc_snapshot_out", got, 8'h81);
        check("tc_after_frame", tc_q, 8'h00);
        check("regsel_change_ignored", rd_q, 8'h5A);
        check("regsel_change_no_stb", rd_stb_cnt, 1);

        // 6: reset mid-frame clears state and commits nothing
        rd_before = rd_stb_cnt;
        err_before = err_cnt;
        frame_open(2'b10);
        for (int i = 0; i < 4; i++) send_bit(1'b1, o);
        rst_n    = 1'b0;
        rpi_le   = 1'b1;
        rpi_sclk = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rd", rd_q, 8'h00);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(8);
        check("rst_mid_no_stb", rd_stb_cnt - rd_before, 0);
        check("rst_mid_no_err", err_cnt - err_before, 0);
        run_frame(2'b10, 8'hFF, 8, got);
        check("post_rst_rd", rd_q, 8'hFF);
        check("post_rst_stb", rd_stb_cnt - rd_before, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
